// File: rtl/imm_encoder.sv
// imm_encoder: packs instruction fields and a 32-bit immediate into an RV32I
// instruction word (the inverse of the pipeline immediate extender). It is used
// by the boot loader and the self-test stub generator. The LI pseudo-op can
// expand into LUI followed by ADDI, which takes two output beats.
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   req_valid_i/req_ready_o request handshake (ready is combinational)
//   ImmSrc_i                000 I, 001 S, 010 B, 011 U, 100 J, 101 LI, else reserved
//   Opcode_i, Rd_i, Rs1_i, Rs2_i, Funct3_i, Imm_i   instruction fields
//   instr_valid_o/instr_ready_i  output handshake
//   Instr_o, Last_o, ErrRange_o  registered output word and its flags
//   WordCount_o             output handshakes since reset (wraps)
module imm_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            ImmSrc_i,
  input  logic [6:0]            Opcode_i,
  input  logic [4:0]            Rd_i,
  input  logic [4:0]            Rs1_i,
  input  logic [4:0]            Rs2_i,
  input  logic [2:0]            Funct3_i,
  input  logic [DATA_WIDTH-1:0] Imm_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic                  Last_o,
  output logic                  ErrRange_o,
  output logic [CNT_WIDTH-1:0]  WordCount_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_LI_HI = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] word;
    logic                  last;
    logic                  err;
    logic                  split;
    logic [DATA_WIDTH-1:0] addi;
  } enc_t;

  // Encode one request. For a split LI, 'word' is the LUI and 'addi' the
  // second beat.
  function automatic enc_t encode(
    input logic [2:0]            src,
    input logic [6:0]            op,
    input logic [4:0]            rd,
    input logic [4:0]            rs1,
    input logic [4:0]            rs2,
    input logic [2:0]            f3,
    input logic [DATA_WIDTH-1:0] imm
  );
    enc_t        e;
    logic [19:0] hi;
    e.word  = 32'h0000_0013;
    e.last  = 1'b1;
    e.err   = 1'b0;
    e.split = 1'b0;
    e.addi  = 32'h0000_0000;
    // Upper 20 bits of (imm + 0x800): rounding compensates for ADDI sign-extension.
    hi      = imm[31:12] + {19'd0, imm[11]};
    case (src)
      3'b000: begin
        e.word = {imm[11:0], rs1, f3, rd, op};
        e.err  = (imm[31:11] != {21{imm[31]}});
      end
      3'b001: begin
        e.word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        e.err  = (imm[31:11] != {21{imm[31]}});
      end
      3'b010: begin
        e.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e.err  = imm[0] | (imm[31:12] != {20{imm[31]}});
      end
      3'b011: begin
        e.word = {imm[31:12], rd, op};
        e.err  = (imm[11:0] != 12'd0);
      end
      3'b100: begin
        e.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        e.err  = imm[0] | (imm[31:20] != {12{imm[31]}});
      end
      3'b101: begin
        if (imm[31:11] == {21{imm[31]}}) begin
          e.word = {imm[11:0], 5'd0, 3'b000, rd, 7'h13};
        end else begin
          e.word = {hi, rd, 7'h37};
          if (imm[11:0] != 12'd0) begin
            e.split = 1'b1;
            e.last  = 1'b0;
            e.addi  = {imm[11:0], rd, 3'b000, rd, 7'h13};
          end else begin
            e.split = 1'b0;
          end
        end
      end
      default: begin
        e.word = 32'h0000_0013;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  accept_s;
  logic                  fire_s;
  enc_t                  enc_s;

  // Request-side ready depends on state; in LI_HI the ADDI beat owns the slot.
  always_comb begin
    case (state_q)
      ST_EMPTY: req_ready_o = 1'b1;
      ST_FULL:  req_ready_o = instr_ready_i;
      ST_LI_HI: req_ready_o = 1'b0;
      default:  req_ready_o = 1'b0;
    endcase
  end

  assign accept_s = req_valid_i & req_ready_o;
  assign fire_s   = valid_q & instr_ready_i;
  assign enc_s    = encode(ImmSrc_i, Opcode_i, Rd_i, Rs1_i, Rs2_i, Funct3_i, Imm_i);

  // Next-state logic for the output stage.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pend_d  = pend_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, fire_s};
    // Accept only happens when the slot is empty or is draining this cycle.
    if (accept_s) begin
      instr_d = enc_s.word;
      last_d  = enc_s.last;
      err_d   = enc_s.err;
      pend_d  = enc_s.addi;
      valid_d = 1'b1;
      state_d = enc_s.split ? ST_LI_HI : ST_FULL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          valid_d = 1'b0;
        end
        ST_FULL: begin
          if (fire_s) begin
            valid_d = 1'b0;
            state_d = ST_EMPTY;
          end else begin
            valid_d = 1'b1;
          end
        end
        ST_LI_HI: begin
          if (fire_s) begin
            instr_d = pend_q;
            last_d  = 1'b1;
            err_d   = 1'b0;
            state_d = ST_FULL;
          end else begin
            valid_d = 1'b1;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
      instr_q <= '0;
      pend_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_valid_o = valid_q;
  assign Instr_o       = instr_q;
  assign Last_o        = last_q;
  assign ErrRange_o    = err_q;
  assign WordCount_o   = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    imm_src;
  logic [6:0]    opcode;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [DW-1:0] imm;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic          last;
  logic          err_range;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  imm_encoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .ImmSrc_i(imm_src), .Opcode_i(opcode), .Rd_i(rd), .Rs1_i(rs1), .Rs2_i(rs2),
    .Funct3_i(funct3), .Imm_i(imm),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .Instr_o(instr), .Last_o(last), .ErrRange_o(err_range), .WordCount_o(word_count)
  );

  // Scoreboard entries: {err, last, word}
  logic [33:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit          rand_ready = 1'b0;
  bit          held_v = 1'b0;
  logic [63:0] held_w = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic void push(input logic e, input logic l, input logic [31:0] w);
    exp_q.push_back({e, l, w});
  endfunction

  // Reference model: expected words from field positions and signed ranges.
  function automatic void model(input logic [2:0] src, input logic [6:0] op,
                                input logic [4:0] r_d, input logic [4:0] r_s1,
                                input logic [4:0] r_s2, input logic [2:0] f3,
                                input logic [31:0] v);
    int          s;
    logic [31:0] w, hi, lo, base;
    s = $signed(v);
    base = (32'(r_s1) << 15) | (32'(f3) << 12) | 32'(op);
    case (src)
      3'd0: begin
        w = ((v & 32'hFFF) << 20) | base | (32'(r_d) << 7);
        push(s < -2048 || s > 2047, 1'b1, w);
      end
      3'd1: begin
        w = (((v >> 5) & 32'h7F) << 25) | (32'(r_s2) << 20) | base | ((v & 32'h1F) << 7);
        push(s < -2048 || s > 2047, 1'b1, w);
      end
      3'd2: begin
        w = (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25) | (32'(r_s2) << 20) | base
            | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
        push(((v & 32'h1) != 32'h0) || s < -4096 || s > 4095, 1'b1, w);
      end
      3'd3: begin
        w = ((v >> 12) << 12) | (32'(r_d) << 7) | 32'(op);
        push((v & 32'hFFF) != 32'h0, 1'b1, w);
      end
      3'd4: begin
        w = (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21) | (((v >> 11) & 32'h1) << 20)
            | (((v >> 12) & 32'hFF) << 12) | (32'(r_d) << 7) | 32'(op);
        push(((v & 32'h1) != 32'h0) || s < -1048576 || s > 1048575, 1'b1, w);
      end
      3'd5: begin
        if (s >= -2048 && s <= 2047) begin
          push(1'b0, 1'b1, ((v & 32'hFFF) << 20) | (32'(r_d) << 7) | 32'h13);
        end else begin
          hi = (v + 32'h800) >> 12;
          lo = v & 32'hFFF;
          push(1'b0, lo == 32'h0, (hi << 12) | (32'(r_d) << 7) | 32'h37);
          if (lo != 32'h0) push(1'b0, 1'b1, (lo << 20) | (32'(r_d) << 15) | (32'(r_d) << 7) | 32'h13);
        end
      end
      default: push(1'b1, 1'b1, 32'h0000_0013);
    endcase
  endfunction

  // Monitor: pop and compare on every output handshake; check hold and count.
  always @(negedge clk) begin
    logic [63:0] act;
    logic [33:0] e;
    act = {30'd0, err_range, last, instr};
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = '0;
      held_v  = 1'b0;
    end else if (instr_valid) begin
      chk("wordcount", 64'(word_count), 64'(exp_cnt));
      if (held_v) chk("hold", act, held_w);
      if (instr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: actual %h required none", act);
        end else begin
          e = exp_q.pop_front();
          chk("word", act, 64'(e));
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      held_v = !instr_ready;
      held_w = act;
    end else begin
      held_v = 1'b0;
    end
  end

  // Random consumer back-pressure.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 instr_ready = ($urandom % 10) < 7;
    end
  end

  task automatic send(input logic [2:0] src, input logic [6:0] op, input logic [4:0] r_d,
                      input logic [4:0] r_s1, input logic [4:0] r_s2, input logic [2:0] f3,
                      input logic [31:0] v);
    imm_src = src; opcode = op; rd = r_d; rs1 = r_s1; rs2 = r_s2; funct3 = f3; imm = v;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        model(src, op, r_d, r_s1, r_s2, f3, v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL accept_timeout: actual no accept required accept");
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL drain_timeout: actual %0d left required 0", exp_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] cnt0;
    time t0;
    rst_n = 1'b0; req_valid = 1'b0; instr_ready = 1'b1;
    imm_src = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; imm = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_err", 64'(err_range), 64'd0);
    chk("rst_count", 64'(word_count), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF);
    chk("i_latency_valid", 64'(instr_valid), 64'd1);
    chk("i_word", {30'd0, err_range, last, instr}, {30'd0, 1'b0, 1'b1, 32'hFFF0_0093});
    send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
    chk("b_word", {30'd0, err_range, instr}, {30'd0, 1'b0, 32'h0020_8463});
    send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    chk("b_odd_err", 64'(err_range), 64'd1);
    drain();

    cnt0 = word_count;
    send(3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
    chk("li_hi", {30'd0, req_ready, last, instr}, {30'd0, 1'b0, 1'b0, 32'h1234_62B7});
    @(posedge clk); #1;
    chk("li_lo", {31'd0, last, instr}, {31'd0, 1'b1, 32'hFFF2_8293});
    drain();
    chk("li_count", 64'(word_count), 64'(cnt0 + 16'd2));

    send(3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0001_0000);
    chk("li_nolow", {31'd0, last, instr}, {31'd0, 1'b1, 32'h0001_02B7});
    send(3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 32'hFFFF_F800);
    chk("li_neg", {31'd0, last, instr}, {31'd0, 1'b1, 32'h8000_0293});
    send(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0000);
    chk("j_range", 64'(err_range), 64'd1);
    send(3'd3, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_1001);
    chk("u_range", 64'(err_range), 64'd1);
    send(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 32'h0000_0010);
    chk("reserved", {31'd0, err_range, instr}, {31'd0, 1'b1, 32'h0000_0013});
    drain();

    // Back-pressure during the LUI beat.
    instr_ready = 1'b0;
    send(3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
    imm_src = 3'd0; imm = 32'd1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {31'd0, req_ready, instr}, {31'd0, 1'b0, 32'h1234_62B7});
    end
    req_valid = 1'b0;
    instr_ready = 1'b1;
    drain();

    // Back-to-back I requests: one accept per cycle.
    t0 = $time;
    for (int i = 0; i < 4; i++) send(3'd0, 7'h13, 5'(i + 1), 5'd2, 5'd0, 3'd0, 32'(i * 7));
    chk("throughput", 64'($time - t0), 64'd40);
    drain();

    // Reset while the ADDI beat is pending.
    instr_ready = 1'b0;
    send(3'd5, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_li_valid", 64'(instr_valid), 64'd0);
    chk("rst_li_count", 64'(word_count), 64'd0);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_li_no_addi", 64'(instr_valid), 64'd0);

    // Randomized phase.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: v = $urandom & 32'hFFFF_F000;
        default: v = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      endcase
      send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), v);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    instr_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the pipeline immediate extender: packs instruction fields and a 32-bit immediate into a 32-bit RV32I instruction word.
- Serves the boot/program loader and self-test stub generator, which stream encoded words into instruction memory.
- Supports a LI pseudo-op that expands into LUI+ADDI over two output beats.
- Valid/ready on both sides; one registered output stage.

Parameters:
DATA_WIDTH, 32, instruction/immediate width (only 32 supported)
CNT_WIDTH, 16, width of emitted-word counter

Ports:
clk_i  input  1  clock
rst_n_i  input  1  synchronous active-low reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when valid&ready
ImmSrc_i  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 LI, others reserved
Opcode_i  input  7  opcode field (ignored for LI)
Rd_i  input  5  rd
Rs1_i  input  5  rs1
Rs2_i  input  5  rs2
Funct3_i  input  3  funct3
Imm_i  input  DATA_WIDTH  immediate value (byte offset for B/J)
instr_valid_o  output  1  output word valid
instr_ready_i  input  1  consumer ready
Instr_o  output  DATA_WIDTH  encoded instruction
Last_o  output  1  final word of the current request
ErrRange_o  output  1  immediate not representable (qualified by instr_valid_o)
WordCount_o  output  CNT_WIDTH  output handshakes since reset, wraps

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge): state EMPTY; instr_valid_o=0, Instr_o=0, Last_o=0, ErrRange_o=0, WordCount_o=0.
- Reset mid-LI discards the pending ADDI.
- States and req_ready_o (combinational):
  - EMPTY: req_ready_o=1.
  - FULL (one word held, none pending): req_ready_o=instr_ready_i.
  - LI_HI (LUI held, ADDI pending): req_ready_o=0.
- Latency: accepted request appears on Instr_o the next cycle. Throughput is 1 word/cycle under continuous instr_ready_i.
- Output handshake (instr_valid_o & instr_ready_i):
  - WordCount_o increments.
  - FULL with no new request goes to EMPTY.
  - FULL with a simultaneous request reloads and stays FULL (or enters LI_HI).
  - LI_HI loads ADDI, Last_o=1, and goes to FULL.
- Stability: while instr_valid_o=1 and instr_ready_i=0, Instr_o, Last_o and ErrRange_o are held stable.
- Encodings, with fields at standard RV32I positions:
  - I: Imm[11:0] goes to [31:20].
  - S: Imm[11:5] goes to [31:25]; Imm[4:0] goes to [11:7].
  - B: [31]=Imm[12], [30:25]=Imm[10:5], [11:8]=Imm[4:1], [7]=Imm[11].
  - U: [31:12]=Imm[31:12].
  - J: [31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12].
  - Unused register fields per type are dropped.
- Range check sets ErrRange_o=1. The word is still emitted with truncated fields.
  - I and S: Imm[31:11] not all-equal.
  - B: Imm[0]=1, or Imm[31:12] not all-equal.
  - J: Imm[0]=1, or Imm[31:20] not all-equal.
  - U: Imm[11:0]!=0.
  - Reserved ImmSrc: emit 0x00000013 (NOP), ErrRange_o=1.
- Last_o=1 for every non-LI word.
- LI (never errors; Opcode/Rs/Funct3 ignored):
  - If Imm fits 12-bit signed: single ADDI rd,x0,Imm (opcode 0x13, funct3 000), Last_o=1.
  - Otherwise: hi=(Imm+0x800)[31:12] (32-bit wrap), lo=Imm[11:0].
  - Emit LUI rd,hi (opcode 0x37).
  - If lo!=0: LUI goes out with Last_o=0 via LI_HI, then ADDI rd,rd,lo with Last_o=1.
  - If lo==0: LUI alone with Last_o=1, state FULL.
- Round-trip property: for in-range requests, sign-extending the emitted immediate with the pipeline's ImmSrc decoding returns Imm_i.

Test Plan:
- I: Opcode 0x13, Rd 1, Rs1 0, Funct3 0, Imm 0xFFFFFFFF -> Instr_o 0xFFF00093, Last_o 1, ErrRange_o 0, one cycle after accept.
- B: Opcode 0x63, Rs1 1, Rs2 2, Funct3 0, Imm 8 -> 0x00208463. Same with Imm 3 -> ErrRange_o 1.
- LI split: Rd 5, Imm 0x12345FFF -> beat 1: 0x123462B7, Last_o 0, req_ready_o 0; beat 2: 0xFFF28293, Last_o 1. WordCount_o +2.
- LI no-low: Rd 5, Imm 0x00010000 -> single 0x000102B7, Last_o 1. LI with Imm 0xFFFFF800 -> single 0x80000293.
- Range: J Imm 0x00100000 -> ErrRange_o 1. U Imm 0x00001001 -> ErrRange_o 1. ImmSrc 111 -> 0x00000013, ErrRange_o 1.
- Back-pressure and reset:
  - instr_ready_i low 3 cycles during LI beat 1 -> Instr_o held at 0x123462B7, no new accept.
  - Back-to-back I requests with ready high -> 1 word/cycle.
  - rst_n_i low while in LI_HI -> next cycle instr_valid_o 0, WordCount_o 0, ADDI never emitted.
